data_memory_dump: RTL and testbench

//  Data-memory responder on the processor's DM port: executes stores, serves combinational loads.
//  On a dump request, streams every memory word out over a valid/ready port for bench/host checking.

---
 rtl/processor_pkg.sv | 14 +
 rtl/dm_storage.sv | 34 +++
 rtl/data_memory_dump.sv | 131 +++++++++++++
 tb/tb_data_memory_dump.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// Shared widths and the dump sequencer state type for the
// processor's data-memory side.
package processor_pkg;

    localparam int N_DEFAULT     = 64;
    localparam int DEPTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/dm_storage.sv
// Word-addressed register file for data memory: async clear,
// one synchronous write port, two combinational read ports.
module dm_storage #(
    parameter int N         = 64,
    parameter int DEPTH     = 32,
    parameter int ADDR_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [N-1:0]         wdata,
    input  logic [ADDR_BITS-1:0] raddr_a,
    output logic [N-1:0]         rdata_a,
    input  logic [ADDR_BITS-1:0] raddr_b,
    output logic [N-1:0]         rdata_b
);

    logic [N-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/data_memory_dump.sv
// Data-memory responder: stores, combinational loads, and a
// valid/ready stream of every word on a dump request.
module data_memory_dump
    import processor_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [N-1:0]         DM_addr,
    input  logic [N-1:0]         DM_writeData,
    input  logic                 DM_writeEnable,
    input  logic                 DM_readEnable,
    output logic [N-1:0]         DM_readData,
    input  logic                 dump,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [ADDR_BITS-1:0] dump_addr,
    output logic [N-1:0]         dump_data,
    output logic                 dump_done,
    output logic                 busy
);

    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

    dump_state_t          state;
    dump_state_t          state_next;
    logic [ADDR_BITS-1:0] cnt;
    logic [ADDR_BITS-1:0] cnt_next;
    logic                 dump_q;

    logic [ADDR_BITS-1:0] idx;
    logic                 in_range;
    logic                 store;
    logic [N-1:0]         load_word;
    logic [N-1:0]         dump_word;
    logic                 unused_low_bits;

    // Byte address to word index; the low three bits select a byte
    // within the word and do not matter here.
    assign idx             = DM_addr[ADDR_BITS+2:3];
    assign in_range        = (DM_addr[N-1:ADDR_BITS+3] == '0);
    assign unused_low_bits = ^DM_addr[2:0];

    // Stores freeze while dumping so the stream is a clean snapshot.
    assign store = (state == IDLE) && DM_writeEnable && in_range;

    dm_storage #(
        .N         (N),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_storage (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .we      (store),
        .waddr   (idx),
        .wdata   (DM_writeData),
        .raddr_a (idx),
        .rdata_a (load_word),
        .raddr_b (cnt),
        .rdata_b (dump_word)
    );

    assign DM_readData = (DM_readEnable && in_range) ? load_word : '0;

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            dump_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            dump_q <= dump;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (dump && !dump_q) begin
                    state_next = DUMP;
                    cnt_next   = '0;
                end
            end
            DUMP: begin
                if (dump_ready) begin
                    if (cnt == LAST) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!dump) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        dump_valid = 1'b0;
        busy       = 1'b0;
        dump_done  = 1'b0;
        dump_addr  = '0;
        dump_data  = '0;
        unique case (state)
            DUMP: begin
                dump_valid = 1'b1;
                busy       = 1'b1;
                dump_addr  = cnt;
                dump_data  = dump_word;
            end
            DONE: begin
                dump_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_dump.sv
// Self-checking bench for data_memory_dump: load/store vectors,
// random traffic against a memory model, and dump sequences.
module tb_data_memory_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] DM_addr;
    logic [63:0] DM_writeData;
    logic        DM_writeEnable;
    logic        DM_readEnable;
    logic [63:0] DM_readData;
    logic        dump;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_addr;
    logic [63:0] dump_data;
    logic        dump_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [63:0] ref_mem [32];

    typedef struct {
        logic        we;
        logic        re;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    data_memory_dump dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .DM_addr        (DM_addr),
        .DM_writeData   (DM_writeData),
        .DM_writeEnable (DM_writeEnable),
        .DM_readEnable  (DM_readEnable),
        .DM_readData    (DM_readData),
        .dump           (dump),
        .dump_valid     (dump_valid),
        .dump_ready     (dump_ready),
        .dump_addr      (dump_addr),
        .dump_data      (dump_data),
        .dump_done      (dump_done),
        .busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: a store lands only when the byte address is below 256.
    function automatic void model_store(input logic we,
                                        input logic [63:0] addr,
                                        input logic [63:0] data);
        if (we && addr < 64'd256) ref_mem[addr / 8] = data;
    endfunction

    function automatic logic [63:0] model_load(input logic re,
                                               input logic [63:0] addr);
        if (re && addr < 64'd256) return ref_mem[addr / 8];
        return 64'd0;
    endfunction

    task automatic drive(input logic we, input logic re,
                         input logic [63:0] addr, input logic [63:0] data);
        DM_writeEnable = we;
        DM_readEnable  = re;
        DM_addr        = addr;
        DM_writeData   = data;
    endtask

    // mode 0: ready always, 1: alternate, 2: random.
    task automatic run_dump(input int mode, input int abort_at,
                            input bit inject);
        int beats    = 0;
        int cyc      = 0;
        bit injected = 0;
        dump = 1'b1;
        #1;
        check("valid_latency", {63'd0, dump_valid}, 64'd0);
        tick();
        while (beats < 32 && cyc < 400) begin
            if (beats == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_valid", {63'd0, dump_valid}, 64'd0);
                check("abort_busy", {63'd0, busy}, 64'd0);
                check("abort_done", {63'd0, dump_done}, 64'd0);
                check("abort_addr", {59'd0, dump_addr}, 64'd0);
                check("abort_data", dump_data, 64'd0);
                dump = 1'b0;
                dump_ready = 1'b0;
                drive(1'b0, 1'b0, 64'd0, 64'd0);
                tick();
                reset = 1'b1;
                tick();
                for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
                return;
            end
            case (mode)
                0: dump_ready = 1'b1;
                1: dump_ready = (cyc % 2 == 0);
                default: dump_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject && !injected && beats == 5) begin
                drive(1'b1, 1'b0, 64'h08, 64'hFFFF_0000_FFFF_0000);
                injected = 1;
            end else begin
                drive(1'b0, 1'b0, 64'd0, 64'd0);
            end
            #1;
            check("beat_valid", {63'd0, dump_valid}, 64'd1);
            check("beat_busy", {63'd0, busy}, 64'd1);
            check("beat_addr", {59'd0, dump_addr}, 64'(beats));
            check("beat_data", dump_data, ref_mem[beats]);
            if (dump_ready) beats++;
            cyc++;
            tick();
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        dump_ready = 1'b0;
        check("beat_count", 64'(beats), 64'd32);
        check("done_set", {63'd0, dump_done}, 64'd1);
        check("done_valid", {63'd0, dump_valid}, 64'd0);
        check("done_busy", {63'd0, busy}, 64'd0);
        tick();
        check("hold_done", {63'd0, dump_done}, 64'd1);
        check("no_retrigger", {63'd0, dump_valid}, 64'd0);
        dump = 1'b0;
        tick();
        check("done_clear", {63'd0, dump_done}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset = 1'b0;
        dump = 1'b0;
        dump_ready = 1'b0;
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        for (int i = 0; i < 32; i++) ref_mem[i] = 64'd0;
        tick();
        tick();
        drive(1'b0, 1'b1, 64'h10, 64'd0);
        #1;
        check("rst_rd", DM_readData, 64'd0);
        check("rst_valid", {63'd0, dump_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, dump_done}, 64'd0);
        reset = 1'b1;
        tick();
        check("ld_10", DM_readData, 64'd0);

        vecs[0]  = '{1'b1, 1'b0, 64'h18, 64'hDEAD_BEEF, 64'd0, "st_18"};
        vecs[1]  = '{1'b0, 1'b1, 64'h18, 64'd0, 64'hDEAD_BEEF, "ld_18"};
        vecs[2]  = '{1'b1, 1'b1, 64'h1000, 64'h55, 64'd0, "st_oor"};
        vecs[3]  = '{1'b0, 1'b1, 64'h1000, 64'd0, 64'd0, "ld_oor"};
        vecs[4]  = '{1'b0, 1'b1, 64'h1F, 64'd0, 64'hDEAD_BEEF, "ld_lowbits"};
        vecs[5]  = '{1'b1, 1'b1, 64'h18, 64'h1234, 64'hDEAD_BEEF, "rw_same"};
        vecs[6]  = '{1'b0, 1'b1, 64'h18, 64'd0, 64'h1234, "ld_new"};
        vecs[7]  = '{1'b0, 1'b0, 64'h18, 64'd0, 64'd0, "re_off"};
        vecs[8]  = '{1'b1, 1'b1, 64'hF8, 64'hA5A5, 64'd0, "st_top"};
        vecs[9]  = '{1'b0, 1'b1, 64'hF8, 64'd0, 64'hA5A5, "ld_top"};
        vecs[10] = '{1'b0, 1'b1, 64'h100, 64'd0, 64'd0, "ld_edge_oor"};
        vecs[11] = '{1'b0, 1'b1, 64'h8000_0000_0000_0018, 64'd0, 64'd0,
                     "ld_hi_bit"};
        foreach (vecs[i]) begin
            drive(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
            #1;
            check(vecs[i].name, DM_readData, vecs[i].exp);
            tick();
            model_store(vecs[i].we, vecs[i].addr, vecs[i].wdata);
        end

        for (int i = 0; i < 200; i++) begin
            logic        we;
            logic        re;
            logic [63:0] addr;
            logic [63:0] data;
            we   = 1'($urandom_range(0, 1));
            re   = ($urandom_range(0, 3) != 0);
            data = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) addr = {$urandom, $urandom};
            else addr = 64'($urandom_range(0, 255));
            drive(we, re, addr, data);
            #1;
            check("rand_ld", DM_readData, model_load(re, addr));
            tick();
            model_store(we, addr, data);
        end

        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 64'(i * 8), 64'(i * 3));
            tick();
            model_store(1'b1, 64'(i * 8), 64'(i * 3));
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        tick();
        run_dump(0, -1, 1'b0);
        run_dump(1, -1, 1'b0);
        run_dump(2, -1, 1'b1);
        drive(1'b0, 1'b1, 64'h08, 64'd0);
        #1;
        check("ld_after_dump", DM_readData, ref_mem[1]);
        tick();

        run_dump(0, 10, 1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b1, 64'(i * 8), 64'd0);
            #1;
            check("cleared", DM_readData, ref_mem[i]);
            tick();
        end
        drive(1'b0, 1'b0, 64'd0, 64'd0);
        run_dump(0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
